acc_vec_engine: RTL and testbench

//  Accelerator-side consumer of the memory-mapped accelerator window: receives operand banks A/B
//  (written by the core through the data RAM wrapper) and a start pulse. Streams one word per cycle

---
 rtl/acc_vec_engine_pkg.sv | 26 ++
 rtl/acc_vec_engine_if.sv | 26 ++
 rtl/acc_vec_engine_lane_alu.sv | 39 +++
 rtl/acc_vec_engine.sv | 117 +++++++++++
 tb/tb_acc_vec_engine.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/acc_vec_engine_pkg.sv
// Shared types and default geometry for the accelerator vector engine.
// Operand/result words are LANES packed byte lanes.
package acc_vec_engine_pkg;

  localparam int ACC_NUM_WORDS = 256;
  localparam int ACC_LANES     = 4;
  localparam int ACC_LANE_W    = 8;
  localparam int ACC_DOT_W     = 32;

  typedef logic [ACC_LANES-1:0][ACC_LANE_W-1:0] acc_word_t;

  typedef enum logic [1:0] {
    MODE_ADD  = 2'b00,
    MODE_MUL  = 2'b01,
    MODE_SADD = 2'b10,
    MODE_XOR  = 2'b11
  } acc_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_DRAIN = 2'b10,
    ST_DONE  = 2'b11
  } acc_state_e;

endpackage

// File: rtl/acc_vec_engine_if.sv
// Control/status bundle between the core-side window and the vector engine.
// The master is the core side; the slave is the engine.
interface acc_vec_engine_if;
  import acc_vec_engine_pkg::*;

  // start_i is a request sampled only while the engine is idle; there is no
  // ready and nothing is queued. busy_o stays high for the whole run, and
  // done_o is a single-cycle pulse once acc_out_o and dot_o are final.
  logic                 start_i;
  logic [1:0]           mode_i;
  logic                 busy_o;
  logic                 done_o;
  logic [ACC_DOT_W-1:0] dot_o;
  acc_state_e           state_o;

  modport master (
    output start_i, mode_i,
    input  busy_o, done_o, dot_o, state_o
  );

  modport slave (
    input  start_i, mode_i,
    output busy_o, done_o, dot_o, state_o
  );

endinterface

// File: rtl/acc_vec_engine_lane_alu.sv
// Combinational per-lane word operation plus the sum of the lane products
// that feeds the dot-product accumulator (products are taken in every mode).
module acc_vec_engine_lane_alu
  import acc_vec_engine_pkg::*;
#(
  parameter int LANES  = ACC_LANES,
  parameter int LANE_W = ACC_LANE_W,
  parameter int PSUM_W = 2*LANE_W + $clog2(LANES)
) (
  input  acc_mode_e                     i_mode,
  input  logic [LANES-1:0][LANE_W-1:0]  i_a,
  input  logic [LANES-1:0][LANE_W-1:0]  i_b,
  output logic [LANES-1:0][LANE_W-1:0]  o_res,
  output logic [PSUM_W-1:0]             o_psum
);

  logic [LANES-1:0][2*LANE_W-1:0] w_prod;
  logic [LANES-1:0][LANE_W:0]     w_sum;

  always_comb begin
    w_prod = '0;
    w_sum  = '0;
    o_res  = '0;
    o_psum = '0;
    for (int l = 0; l < LANES; l++) begin
      w_prod[l] = (2*LANE_W)'(i_a[l]) * (2*LANE_W)'(i_b[l]);
      w_sum[l]  = (LANE_W+1)'(i_a[l]) + (LANE_W+1)'(i_b[l]);
      case (i_mode)
        MODE_ADD:  o_res[l] = w_sum[l][LANE_W-1:0];
        MODE_MUL:  o_res[l] = w_prod[l][LANE_W-1:0];
        // Carry out of the lane means the true sum exceeded the lane range.
        MODE_SADD: o_res[l] = w_sum[l][LANE_W] ? {LANE_W{1'b1}} : w_sum[l][LANE_W-1:0];
        default:   o_res[l] = i_a[l] ^ i_b[l];
      endcase
      o_psum = o_psum + PSUM_W'(w_prod[l]);
    end
  end

endmodule

// File: rtl/acc_vec_engine.sv
// Vector engine: walks operand banks A/B one word per cycle through a
// two-stage lane ALU, fills the result bank and accumulates a byte dot product.
module acc_vec_engine
  import acc_vec_engine_pkg::*;
#(
  parameter int NUM_WORDS = ACC_NUM_WORDS,
  parameter int LANES     = ACC_LANES,
  parameter int LANE_W    = ACC_LANE_W
) (
  input  logic                          clk,
  input  logic                          rst_i,
  acc_vec_engine_if.slave               bus,
  input  logic [LANES-1:0][LANE_W-1:0]  acc_in_A_i [NUM_WORDS],
  input  logic [LANES-1:0][LANE_W-1:0]  acc_in_B_i [NUM_WORDS],
  output logic [LANES-1:0][LANE_W-1:0]  acc_out_o  [NUM_WORDS]
);

  localparam int IDX_W  = $clog2(NUM_WORDS);
  localparam int PSUM_W = 2*LANE_W + $clog2(LANES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  typedef logic [LANES-1:0][LANE_W-1:0] word_t;

  acc_state_e           r_state;
  acc_mode_e            r_mode;
  logic [IDX_W-1:0]     r_idx;
  logic                 r_s1_valid;
  word_t                r_s1_a;
  word_t                r_s1_b;
  logic [IDX_W-1:0]     r_s1_idx;
  word_t                r_out [NUM_WORDS];
  logic [ACC_DOT_W-1:0] r_dot;
  logic                 r_busy;
  logic                 r_done;

  word_t                w_res;
  logic [PSUM_W-1:0]    w_psum;

  acc_vec_engine_lane_alu #(
    .LANES  (LANES),
    .LANE_W (LANE_W),
    .PSUM_W (PSUM_W)
  ) u_lane_alu (
    .i_mode (r_mode),
    .i_a    (r_s1_a),
    .i_b    (r_s1_b),
    .o_res  (w_res),
    .o_psum (w_psum)
  );

  always_ff @(posedge clk) begin
    if (rst_i) begin
      r_state    <= ST_IDLE;
      r_mode     <= MODE_ADD;
      r_idx      <= '0;
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_idx   <= '0;
      r_dot      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      for (int i = 0; i < NUM_WORDS; i++) r_out[i] <= '0;
    end else begin
      r_s1_valid <= 1'b0;
      r_done     <= 1'b0;

      // Stage 2 retires whatever stage 1 captured on the previous edge.
      if (r_s1_valid) begin
        r_out[r_s1_idx] <= w_res;
        r_dot           <= r_dot + ACC_DOT_W'(w_psum);
      end

      case (r_state)
        ST_IDLE: begin
          if (bus.start_i) begin
            r_mode  <= acc_mode_e'(bus.mode_i);
            r_idx   <= '0;
            r_dot   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_s1_valid <= 1'b1;
          r_s1_a     <= acc_in_A_i[r_idx];
          r_s1_b     <= acc_in_B_i[r_idx];
          r_s1_idx   <= r_idx;
          if (r_idx == LAST_IDX) begin
            r_state <= ST_DRAIN;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        ST_DRAIN: begin
          // The last word retires on this edge, so results are final next cycle.
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= ST_DONE;
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign acc_out_o   = r_out;
  assign bus.dot_o   = r_dot;
  assign bus.busy_o  = r_busy;
  assign bus.done_o  = r_done;
  assign bus.state_o = r_state;

endmodule

// File: tb/tb_acc_vec_engine.sv
// Bench for acc_vec_engine: vector table, random runs against a lane model,
// and hand-written sequences for ignored starts and mid-run reset.
module tb_acc_vec_engine;
  import acc_vec_engine_pkg::*;

  localparam int N = ACC_NUM_WORDS;

  logic      clk;
  logic      rst_i;
  acc_word_t a_bank   [N];
  acc_word_t b_bank   [N];
  acc_word_t out_bank [N];

  acc_vec_engine_if bus ();

  acc_vec_engine dut (
    .clk        (clk),
    .rst_i      (rst_i),
    .bus        (bus),
    .acc_in_A_i (a_bank),
    .acc_in_B_i (b_bank),
    .acc_out_o  (out_bank)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] model_byte(input logic [1:0] m, input logic [7:0] a, input logic [7:0] b);
    int s;
    case (m)
      2'd0: return 8'((int'(a) + int'(b)) % 256);
      2'd1: return 8'((int'(a) * int'(b)) % 256);
      2'd2: begin
        s = int'(a) + int'(b);
        return (s > 255) ? 8'hFF : 8'(s);
      end
      default: return a ^ b;
    endcase
  endfunction

  function automatic logic [31:0] model_dot();
    longint sum = 0;
    for (int k = 0; k < N; k++)
      for (int l = 0; l < ACC_LANES; l++)
        sum += longint'(a_bank[k][l]) * longint'(b_bank[k][l]);
    return 32'(sum % 64'h1_0000_0000);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic fill_uniform(input logic [7:0] a, input logic [7:0] b);
    for (int k = 0; k < N; k++) begin
      a_bank[k] = {4{a}};
      b_bank[k] = {4{b}};
    end
  endtask

  task automatic fill_random();
    for (int k = 0; k < N; k++) begin
      a_bank[k] = $urandom;
      b_bank[k] = $urandom;
    end
  endtask

  // Cycle c of the window is the cycle after start was sampled plus c-1.
  task automatic run_engine(input logic [1:0] m, input int mid_pulse, input bit done_pulse,
                            output int done_at, output int busy_cnt, output int done_cnt,
                            output logic [31:0] dot_at1, output logic busy_at_done);
    done_at = -1; busy_cnt = 0; done_cnt = 0; dot_at1 = '1; busy_at_done = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.mode_i  = m;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    bus.mode_i  = ~m;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      bus.start_i = 1'b0;
      if (c == 1) dot_at1 = bus.dot_o;
      if (bus.busy_o) busy_cnt++;
      if (bus.done_o) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at      = c;
          busy_at_done = bus.busy_o;
        end
        if (done_pulse) bus.start_i = 1'b1;
      end
      if (c == mid_pulse) bus.start_i = 1'b1;
    end
    bus.start_i = 1'b0;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check_bank(input string name, input logic [1:0] m);
    logic [31:0] exp_q[$];
    logic [31:0] w;
    logic [31:0] e;
    int bad = 0;
    int first = -1;
    logic [31:0] fa = '0;
    logic [31:0] fe = '0;
    for (int k = 0; k < N; k++) begin
      for (int l = 0; l < ACC_LANES; l++)
        w[l*8 +: 8] = model_byte(m, a_bank[k][l], b_bank[k][l]);
      exp_q.push_back(w);
    end
    for (int k = 0; k < N; k++) begin
      e = exp_q.pop_front();
      if (out_bank[k] !== e) begin
        bad++;
        if (first < 0) begin
          first = k; fa = out_bank[k]; fe = e;
        end
      end
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL %s_bank: %0d words wrong, word %0d got %08h want %08h", name, bad, first, fa, fe);
    end
    check({name, "_dot"}, 64'(bus.dot_o), 64'(model_dot()));
  endtask

  task automatic check_bank_zero(input string name);
    int bad = 0;
    for (int k = 0; k < N; k++) if (out_bank[k] !== '0) bad++;
    check(name, 64'(bad), 64'd0);
  endtask

  typedef struct {
    logic [1:0]  mode;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [7:0]  exp_byte;
    logic [31:0] exp_dot;
  } vec_t;

  vec_t vecs [8];

  int          done_at, busy_cnt, done_cnt;
  logic [31:0] dot1;
  logic        busy_done;

  initial begin
    vecs[0] = '{2'd1, 8'hFF, 8'h02, 8'hFE, 32'd522240};
    vecs[1] = '{2'd2, 8'hF0, 8'h20, 8'hFF, 32'd7864320};
    vecs[2] = '{2'd2, 8'h10, 8'h20, 8'h30, 32'd524288};
    vecs[3] = '{2'd3, 8'hAA, 8'h0F, 8'hA5, 32'd2611200};
    vecs[4] = '{2'd0, 8'h80, 8'h90, 8'h10, 32'd18874368};
    vecs[5] = '{2'd1, 8'h10, 8'h11, 8'h10, 32'd278528};
    vecs[6] = '{2'd2, 8'hFF, 8'h01, 8'hFF, 32'd261120};
    vecs[7] = '{2'd2, 8'h7F, 8'h80, 8'hFF, 32'd16646144};

    fill_uniform(8'h00, 8'h00);
    bus.start_i = 1'b1;
    bus.mode_i  = 2'd3;
    rst_i       = 1'b1;

    // Reset held two cycles with start asserted.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 64'(bus.busy_o), 64'd0);
    bus.start_i = 1'b0;
    rst_i       = 1'b0;
    @(negedge clk);
    check("rst_state", 64'(bus.state_o), 64'(ST_IDLE));
    check("rst_dot",   64'(bus.dot_o),   64'd0);
    check("rst_done",  64'(bus.done_o),  64'd0);
    check("rst_busy2", 64'(bus.busy_o),  64'd0);
    check_bank_zero("rst_bank");

    // ADD with A[k]=B[k]={4{k}}: timing and contents.
    for (int k = 0; k < N; k++) begin
      a_bank[k] = {4{8'(k)}};
      b_bank[k] = {4{8'(k)}};
    end
    run_engine(2'd0, 0, 1'b0, done_at, busy_cnt, done_cnt, dot1, busy_done);
    check("add_done_at",   64'(done_at),   64'd258);
    check("add_busy_cnt",  64'(busy_cnt),  64'd257);
    check("add_done_cnt",  64'(done_cnt),  64'd1);
    check("add_busy_done", 64'(busy_done), 64'd0);
    check("add_word200",   64'(out_bank[200]), 64'h90909090);
    check_bank("add_ramp", 2'd0);

    // Uniform-byte vector table.
    for (int v = 0; v < 8; v++) begin
      fill_uniform(vecs[v].a, vecs[v].b);
      run_engine(vecs[v].mode, 0, 1'b0, done_at, busy_cnt, done_cnt, dot1, busy_done);
      begin
        int bad = 0;
        for (int k = 0; k < N; k++) if (out_bank[k] !== {4{vecs[v].exp_byte}}) bad++;
        check($sformatf("vec%0d_words", v), 64'(bad), 64'd0);
      end
      check($sformatf("vec%0d_word0", v), 64'(out_bank[0]), 64'({4{vecs[v].exp_byte}}));
      check($sformatf("vec%0d_dot", v), 64'(bus.dot_o), 64'(vecs[v].exp_dot));
      check($sformatf("vec%0d_done_cnt", v), 64'(done_cnt), 64'd1);
    end

    // Random banks and modes against the model.
    for (int r = 0; r < 5; r++) begin
      logic [1:0] m;
      m = 2'($urandom_range(0, 3));
      fill_random();
      run_engine(m, 0, 1'b0, done_at, busy_cnt, done_cnt, dot1, busy_done);
      check($sformatf("rnd%0d_done_at", r), 64'(done_at), 64'd258);
      check_bank($sformatf("rnd%0d", r), m);
    end

    // Starts mid-run and in the DONE cycle are ignored.
    fill_random();
    run_engine(2'd1, 50, 1'b1, done_at, busy_cnt, done_cnt, dot1, busy_done);
    check("ign_done_cnt", 64'(done_cnt), 64'd1);
    check("ign_done_at",  64'(done_at),  64'd258);
    check("ign_busy_cnt", 64'(busy_cnt), 64'd257);
    check("ign_state",    64'(bus.state_o), 64'(ST_IDLE));
    check_bank("ign_mul", 2'd1);
    run_engine(2'd3, 0, 1'b0, done_at, busy_cnt, done_cnt, dot1, busy_done);
    check("restart_dot_clear", 64'(dot1), 64'd0);
    check("restart_done_cnt",  64'(done_cnt), 64'd1);
    check_bank("restart_xor", 2'd3);

    // Reset 100 cycles into a run.
    fill_random();
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.mode_i  = 2'd0;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    repeat (100) @(negedge clk);
    check("mid_busy_before", 64'(bus.busy_o), 64'd1);
    rst_i = 1'b1;
    @(negedge clk);
    check("mid_rst_state", 64'(bus.state_o), 64'(ST_IDLE));
    check("mid_rst_busy",  64'(bus.busy_o),  64'd0);
    check("mid_rst_dot",   64'(bus.dot_o),   64'd0);
    check_bank_zero("mid_rst_bank");
    rst_i = 1'b0;
    begin
      int dones = 0;
      for (int c = 0; c < 200; c++) begin
        @(negedge clk);
        if (bus.done_o) dones++;
      end
      check("mid_rst_no_done", 64'(dones), 64'd0);
    end
    run_engine(2'd2, 0, 1'b0, done_at, busy_cnt, done_cnt, dot1, busy_done);
    check("post_rst_done_at", 64'(done_at), 64'd258);
    check_bank("post_rst_sadd", 2'd2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
